// File: rtl/muladd_pkg.sv
// rtl/muladd_pkg.sv - shared defaults and types for the shared mul-add arbiter
package muladd_pkg;

    localparam int MULADD_NUM_REQ = 4;
    localparam int MULADD_WIDTH   = 8;
    localparam int TAG_W          = $clog2(MULADD_NUM_REQ);

    typedef logic [TAG_W-1:0] tag_t;

    typedef struct packed {
        logic [MULADD_WIDTH-1:0] a;
        logic [MULADD_WIDTH-1:0] b;
        logic [MULADD_WIDTH-1:0] c;
    } operand_t;

endpackage

// File: rtl/muladd_pipe.sv
// rtl/muladd_pipe.sv - pipelined y = a*b + c unit with a requester tag riding alongside
module muladd_pipe
    import muladd_pkg::*;
#(
    parameter int WIDTH   = MULADD_WIDTH,
    parameter int LATENCY = 2,
    parameter int TAG_W_P = TAG_W
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    input  logic [TAG_W_P-1:0] in_tag,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   c,
    output logic               out_valid,
    output logic [TAG_W_P-1:0] out_tag,
    output logic [WIDTH-1:0]   y
);

    logic [WIDTH-1:0]   y_q   [LATENCY];
    logic [TAG_W_P-1:0] tag_q [LATENCY];
    logic [LATENCY-1:0] vld_q;
    logic [WIDTH-1:0]   sum;

    // Evaluated at WIDTH bits, so product truncation and sum wrap are implicit
    assign sum = a * b + c;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                y_q[s]   <= '0;
                tag_q[s] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            y_q[0]   <= sum;
            tag_q[0] <= in_tag;
            for (int s = 1; s < LATENCY; s++) begin
                vld_q[s] <= vld_q[s-1];
                y_q[s]   <= y_q[s-1];
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign out_valid = vld_q[LATENCY-1];
    assign out_tag   = tag_q[LATENCY-1];
    assign y         = y_q[LATENCY-1];

endmodule

// File: rtl/muladd_share_arbiter.sv
// rtl/muladd_share_arbiter.sv - round-robin sharing of one mul-add unit among requesters
module muladd_share_arbiter
    import muladd_pkg::*;
#(
    parameter int NUM_REQ = MULADD_NUM_REQ,
    parameter int WIDTH   = MULADD_WIDTH,
    parameter int LATENCY = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*WIDTH-1:0] req_c,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [NUM_REQ*WIDTH-1:0] resp_y
);

    localparam int TW = $clog2(NUM_REQ);

    logic [TW-1:0]      rr_ptr;
    logic [TW-1:0]      gnt_idx;
    logic               gnt_any;
    logic [NUM_REQ-1:0] busy;
    logic [NUM_REQ-1:0] eligible;
    logic [WIDTH-1:0]   op_a, op_b, op_c;
    logic               out_valid;
    logic [TW-1:0]      out_tag;
    logic [WIDTH-1:0]   out_y;

    assign eligible = req_valid & ~busy;

    // First eligible index at or after rr_ptr, wrapping; gated by reset
    always_comb begin
        req_ready = '0;
        gnt_idx   = '0;
        gnt_any   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!gnt_any && eligible[(int'(rr_ptr) + k) % NUM_REQ]) begin
                gnt_any = reset_n;
                gnt_idx = TW'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
        if (gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign op_a = req_a[gnt_idx*WIDTH +: WIDTH];
    assign op_b = req_b[gnt_idx*WIDTH +: WIDTH];
    assign op_c = req_c[gnt_idx*WIDTH +: WIDTH];

    muladd_pipe #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY),
        .TAG_W_P (TW)
    ) u_pipe (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (gnt_any),
        .in_tag    (gnt_idx),
        .a         (op_a),
        .b         (op_b),
        .c         (op_c),
        .out_valid (out_valid),
        .out_tag   (out_tag),
        .y         (out_y)
    );

    // busy spans grant to consumption, so a release and re-grant never share a cycle
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rr_ptr     <= '0;
            busy       <= '0;
            resp_valid <= '0;
            resp_y     <= '0;
        end else begin
            if (gnt_any) begin
                rr_ptr <= (gnt_idx == TW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && req_valid[i]) begin
                    busy[i] <= 1'b1;
                end else if (resp_valid[i] && resp_ready[i]) begin
                    busy[i] <= 1'b0;
                end
                if (out_valid && out_tag == TW'(i)) begin
                    resp_valid[i]              <= 1'b1;
                    resp_y[i*WIDTH +: WIDTH]   <= out_y;
                end else if (resp_valid[i] && resp_ready[i]) begin
                    resp_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_muladd_share_arbiter.sv
// tb/tb_muladd_share_arbiter.sv - directed self-checking bench for muladd_share_arbiter
module tb_muladd_share_arbiter;
    import muladd_pkg::*;

    localparam int N = 4;
    localparam int W = 8;
    localparam int L = 2;

    logic           clock = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req_valid, req_ready, resp_valid, resp_ready;
    logic [N*W-1:0] req_a, req_b, req_c, resp_y;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    muladd_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .LATENCY(L)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_c      (req_c),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_y     (resp_y)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ops(input int i, input operand_t op);
        req_a[i*W +: W] = op.a;
        req_b[i*W +: W] = op.b;
        req_c[i*W +: W] = op.c;
    endtask

    function automatic logic [W-1:0] y_of(input int i);
        return resp_y[i*W +: W];
    endfunction

    task automatic do_reset();
        reset_n    = 1'b0;
        req_valid  = '0;
        resp_ready = '0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic run_one(input string tag, input int i, input operand_t op, input logic [W-1:0] exp);
        int cyc;
        set_ops(i, op);
        req_valid = N'(1) << i;
        #1;
        check_eq({tag, " ready"}, 32'(req_ready), 32'(1 << i));
        tick();
        req_valid = '0;
        cyc = 0;
        while (!resp_valid[i] && cyc < 10) begin
            tick();
            cyc++;
        end
        check_eq({tag, " latency"}, cyc, L);
        check_eq({tag, " y"}, 32'(y_of(i)), 32'(exp));
        req_valid = N'(1) << i;
        tick();
        check_eq({tag, " hold valid"}, 32'(resp_valid[i]), 1);
        check_eq({tag, " busy no ready"}, 32'(req_ready), 0);
        req_valid = '0;
        resp_ready[i] = 1'b1;
        tick();
        resp_ready = '0;
        check_eq({tag, " consumed"}, 32'(resp_valid[i]), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen, others, r1;
        logic [N-1:0] fexp [10];
        fexp = '{4'b0001, 4'b0100, 4'b0000, 4'b0000, 4'b0001,
                 4'b0100, 4'b0000, 4'b0000, 4'b0001, 4'b0100};
        req_a = '0; req_b = '0; req_c = '0;
        reset_n = 1'b0; req_valid = '1; resp_ready = '0;
        tick();
        tick();
        check_eq("reset req_ready", 32'(req_ready), 0);
        check_eq("reset resp_valid", 32'(resp_valid), 0);
        check_eq("reset resp_y", resp_y, 0);
        req_valid = '0;
        reset_n = 1'b1;
        tick();

        run_one("single", 0, '{a: 8'd4, b: 8'd2, c: 8'd3}, 8'd11);
        run_one("wrap16", 0, '{a: 8'd16, b: 8'd16, c: 8'd5}, 8'd5);
        run_one("wrap255", 2, '{a: 8'd255, b: 8'd255, c: 8'd255}, 8'd0);
        run_one("req3", 3, '{a: 8'd10, b: 8'd30, c: 8'd7}, 8'd51);

        // all four from reset, instant consume
        do_reset();
        resp_ready = '1;
        for (int i = 0; i < N; i++) set_ops(i, '{a: W'(i + 1), b: 8'd2, c: 8'd1});
        req_valid = '1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (c < 4) check_eq($sformatf("order c%0d", c), 32'(req_ready), 32'(1 << c));
            for (int i = 0; i < N; i++) begin
                if (resp_valid[i]) begin
                    seen++;
                    check_eq($sformatf("all4 y%0d", i), 32'(y_of(i)), (i + 1) * 2 + 1);
                end
            end
            tick();
            if (c == 3) req_valid = '0;
        end
        check_eq("all4 responses", seen, 4);

        // requester 1 backpressures its response
        do_reset();
        resp_ready = 4'b1101;
        for (int i = 0; i < N; i++) set_ops(i, '{a: W'(i + 1), b: 8'd2, c: 8'd1});
        req_valid = '1;
        others = 0;
        r1 = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (c >= 2) begin
                if (req_ready[1]) r1++;
                if (req_ready != '0) others++;
            end
            tick();
        end
        check_eq("bp r1 never ready", r1, 0);
        check_eq("bp other grants", others, 8);
        check_eq("bp r1 held valid", 32'(resp_valid[1]), 1);
        check_eq("bp r1 held y", 32'(y_of(1)), 5);
        check_eq("bp c12 grant", 32'(req_ready), 32'(4'b0001));
        resp_ready[1] = 1'b1;
        tick();
        resp_ready = 4'b1101;
        #1;
        check_eq("bp r1 released", 32'(resp_valid[1]), 0);
        check_eq("bp r1 regrant", 32'(req_ready), 32'(4'b0010));
        req_valid = '0;
        resp_ready = '1;
        tick();
        tick();
        tick();
        tick();

        // reset one cycle after a grant
        do_reset();
        set_ops(1, '{a: 8'd3, b: 8'd3, c: 8'd3});
        req_valid = 4'b0010;
        #1;
        check_eq("mid grant", 32'(req_ready), 32'(4'b0010));
        tick();
        reset_n = 1'b0;
        #1;
        check_eq("mid ready in reset", 32'(req_ready), 0);
        tick();
        reset_n = 1'b1;
        req_valid = '0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (resp_valid != '0) seen++;
            tick();
        end
        check_eq("mid no response", seen, 0);
        req_valid = '1;
        #1;
        check_eq("mid ptr restart", 32'(req_ready), 32'(4'b0001));
        req_valid = '0;

        // fairness between 0 and 2
        do_reset();
        resp_ready = '1;
        req_valid = 4'b0101;
        for (int c = 0; c < 10; c++) begin
            #1;
            check_eq($sformatf("fair c%0d", c), 32'(req_ready), 32'(fexp[c]));
            tick();
        end
        req_valid = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
